// File: rtl/dcache_mem_pkg.sv
// Shared types and defaults for the D-cache memory responder.
// Contents: bus widths, BUS_COMMAND encoding, responder FSM states, default
// latency/depth.
package dcache_mem_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned DW              = 64;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_MEM_LATENCY = 2;
  localparam int unsigned DEF_MEM_DEPTH   = 4096;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    WAIT = 2'h1,
    RESP = 2'h2
  } resp_state_e;

endpackage

// File: rtl/dcache_mem_responder_if.sv
// D-cache <-> memory bus.
//   master (cache) : drives dcache2mem_command, cache2mem_addr, cache2mem_data
//   slave  (memory): drives mem2cache_valid, mem2cache_data, mem_busy
interface dcache_mem_responder_if;
  import dcache_mem_pkg::*;

  BUS_COMMAND       dcache2mem_command;
  logic [XLEN-1:0]  cache2mem_addr;
  logic [XLEN-1:0]  cache2mem_data;
  logic             mem2cache_valid;
  logic [DW-1:0]    mem2cache_data;
  logic             mem_busy;

  modport master (
    output dcache2mem_command, cache2mem_addr, cache2mem_data,
    input  mem2cache_valid, mem2cache_data, mem_busy
  );

  modport slave (
    input  dcache2mem_command, cache2mem_addr, cache2mem_data,
    output mem2cache_valid, mem2cache_data, mem_busy
  );

endinterface

// File: rtl/dcache_mem_array.sv
// Doubleword backing store: one synchronous read port, one 32-bit word write
// port with word select. A read and a write to the same index on the same edge
// returns the newly written word.
//   clk, rst         clock / sync active-high reset (read register only)
//   rd_en, rd_idx    capture doubleword rd_idx into rd_data on the next edge
//   rd_data          registered read data (0 after reset)
//   wr_en, wr_idx    write enable / doubleword index
//   wr_sel, wr_data  word select (1 = upper) / word data
module dcache_mem_array
  import dcache_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DW-1:0]     rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_sel,
  input  logic [WORD_W-1:0] wr_data
);

  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) mem_q[wr_idx][DW-1:WORD_W]   <= wr_data;
      else        mem_q[wr_idx][WORD_W-1:0]    <= wr_data;
    end
  end

  // Read with write-first forwarding so a same-edge store is visible.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
      if (wr_en && (wr_idx == rd_idx)) begin
        if (wr_sel) rd_data_d[DW-1:WORD_W] = wr_data;
        else        rd_data_d[WORD_W-1:0]  = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the D-cache bus. Loads return one doubleword as a
// single-cycle mem2cache_valid pulse MEM_LATENCY cycles after acceptance;
// stores write one 32-bit word. One request in flight.
//   clk, rst   clock / synchronous active-high reset
//   bus        dcache_mem_responder_if.slave (command/addr/data in,
//              valid/data/busy out, all registered)
// Optional macro DCMEM_STORE_ACK_EN: stores are accepted only in IDLE, use the
// load timing and return the post-write doubleword with a valid pulse.
module dcache_mem_responder
  import dcache_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  dcache_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] addr_idx_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic             start_c, wr_en_c, rd_en_c;
  logic             unused_addr_c;

  assign addr_idx_c    = bus.cache2mem_addr[IDX_W+2:3];
  assign unused_addr_c = ^{bus.cache2mem_addr[XLEN-1:IDX_W+3], bus.cache2mem_addr[1:0]};

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    start_c = 1'b0;
    wr_en_c = 1'b0;

`ifdef DCMEM_STORE_ACK_EN
    start_c = (state_q == IDLE) &&
              ((bus.dcache2mem_command == BUS_LOAD) || (bus.dcache2mem_command == BUS_STORE));
    wr_en_c = (state_q == IDLE) && (bus.dcache2mem_command == BUS_STORE);
`else
    start_c = (state_q == IDLE) && (bus.dcache2mem_command == BUS_LOAD);
    wr_en_c = (bus.dcache2mem_command == BUS_STORE);
`endif

    case (state_q)
      IDLE: begin
        if (start_c) begin
          idx_d   = addr_idx_c;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read on the edge entering RESP; from IDLE the index is not latched yet.
    rd_en_c  = (state_d == RESP) && (state_q != RESP);
    rd_idx_c = (state_q == IDLE) ? addr_idx_c : idx_q;
    valid_d  = (state_d == RESP);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  logic [DW-1:0] rd_data;

  dcache_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_c),
    .rd_idx  (rd_idx_c),
    .rd_data (rd_data),
    .wr_en   (wr_en_c),
    .wr_idx  (addr_idx_c),
    .wr_sel  (bus.cache2mem_addr[2]),
    .wr_data (bus.cache2mem_data[WORD_W-1:0])
  );

  assign bus.mem2cache_valid = valid_q;
  assign bus.mem_busy        = busy_q;
  assign bus.mem2cache_data  = rd_data;

endmodule
